// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared processor definitions (mul/div op codes and FSM states)
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/b_muldiv_signfix.sv
// ============================================================================
// b_muldiv_signfix : conditional two's-complement negation (abs in / sign out)
// Revision : 1.0
// ============================================================================
`default_nettype none

module b_muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

`default_nettype wire

// File: rtl/b_muldiv.sv
// ============================================================================
// b_muldiv : iterative HI/LO multiply/divide unit (shift-add / restoring)
// Revision : 1.0
// ============================================================================
`default_nettype none

module b_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIV_EN = 1
) (
  input  logic             i_b_muldiv_clk,
  input  logic             i_b_muldiv_rst,
  input  logic             i_b_muldiv_start,
  input  logic [2:0]       i_b_muldiv_op,
  input  logic [WIDTH-1:0] i_b_muldiv_rs,
  input  logic [WIDTH-1:0] i_b_muldiv_rt,
  input  logic             i_b_muldiv_flush,
  output logic             o_b_muldiv_busy,
  output logic             o_b_muldiv_done,
  output logic [WIDTH-1:0] o_b_muldiv_hi,
  output logic [WIDTH-1:0] o_b_muldiv_lo
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             is_mul_q, is_mul_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  md_op_e           op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0] rem_fixed, quot_fixed;

  assign op    = md_op_e'(i_b_muldiv_op);
  assign a_neg = md_is_signed(op) & i_b_muldiv_rs[WIDTH-1];
  assign b_neg = md_is_signed(op) & i_b_muldiv_rt[WIDTH-1];

  b_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_a (
    .i_val (i_b_muldiv_rs),
    .i_neg (a_neg),
    .o_val (a_abs)
  );

  b_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_b (
    .i_val (i_b_muldiv_rt),
    .i_neg (b_neg),
    .o_val (b_abs)
  );

  // Product sign must be applied across the full double-width result.
  b_muldiv_signfix #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .i_val ({acc_hi_q[WIDTH-1:0], acc_lo_q}),
    .i_neg (neg_lo_q),
    .o_val (prod_fixed)
  );

  b_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val (acc_hi_q[WIDTH-1:0]),
    .i_neg (neg_hi_q),
    .o_val (rem_fixed)
  );

  b_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quot (
    .i_val (acc_lo_q),
    .i_neg (neg_lo_q),
    .o_val (quot_fixed)
  );

  // acc_hi holds the running partial product (MUL) or partial remainder (DIV);
  // acc_lo holds the multiplier / dividend bits being consumed.
  assign mul_sum   = acc_hi_q + ({1'b0, bmag_q} & {(WIDTH + 1){acc_lo_q[0]}});
  assign div_trial = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]} - {1'b0, bmag_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    bmag_d   = bmag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_mul_d = is_mul_q;
    div0_d   = div0_q;
    done_d   = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (i_b_muldiv_start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d  = MD_MUL;
              cnt_d    = '0;
              acc_hi_d = '0;
              acc_lo_d = a_abs;
              bmag_d   = b_abs;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
              is_mul_d = 1'b1;
              div0_d   = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              if (DIV_EN != 0) begin
                cnt_d    = '0;
                bmag_d   = b_abs;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;
                is_mul_d = 1'b0;
                // Divide-by-zero parks the dividend as the remainder and
                // skips iteration; FIX restores its sign.
                if (b_abs == '0) begin
                  state_d  = MD_FIX;
                  div0_d   = 1'b1;
                  acc_hi_d = {1'b0, a_abs};
                  acc_lo_d = '0;
                end else begin
                  state_d  = MD_DIV;
                  div0_d   = 1'b0;
                  acc_hi_d = '0;
                  acc_lo_d = a_abs;
                end
              end
            end
            OP_MTHI: begin
              hi_d   = i_b_muldiv_rs;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = i_b_muldiv_rs;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      MD_MUL: begin
        if (i_b_muldiv_flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            state_d = MD_FIX;
          end
        end
      end

      MD_DIV: begin
        if (i_b_muldiv_flush) begin
          state_d = MD_IDLE;
        end else begin
          if (!div_trial[WIDTH]) begin
            acc_hi_d = {1'b0, div_trial[WIDTH-1:0]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            state_d = MD_FIX;
          end
        end
      end

      MD_FIX: begin
        state_d = MD_IDLE;
        if (!i_b_muldiv_flush) begin
          done_d = 1'b1;
          if (is_mul_q) begin
            hi_d = prod_fixed[2*WIDTH-1:WIDTH];
            lo_d = prod_fixed[WIDTH-1:0];
          end else begin
            hi_d = rem_fixed;
            lo_d = div0_q ? '1 : quot_fixed;
          end
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_b_muldiv_clk) begin
    if (i_b_muldiv_rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      bmag_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_mul_q <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      bmag_q   <= bmag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_mul_q <= is_mul_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign o_b_muldiv_busy = (state_q != MD_IDLE);
  assign o_b_muldiv_done = done_q;
  assign o_b_muldiv_hi   = hi_q;
  assign o_b_muldiv_lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_b_muldiv.sv
// ============================================================================
// tb_b_muldiv : scoreboard bench for b_muldiv (WIDTH=32) with arithmetic model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_b_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op_i;
  logic [W-1:0]  rs, rt;
  logic          flush;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] model_hi, model_lo;
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  b_muldiv #(.WIDTH(W), .DIV_EN(1)) dut (
    .i_b_muldiv_clk   (clk),
    .i_b_muldiv_rst   (rst),
    .i_b_muldiv_start (start),
    .i_b_muldiv_op    (op_i),
    .i_b_muldiv_rs    (rs),
    .i_b_muldiv_rt    (rt),
    .i_b_muldiv_flush (flush),
    .o_b_muldiv_busy  (busy),
    .o_b_muldiv_done  (done),
    .o_b_muldiv_hi    (hi),
    .o_b_muldiv_lo    (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic; also yields latency and busy count.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, b,
                                input logic [W-1:0] cur_hi, cur_lo,
                                output bit hd, output int lat, output int bsy,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    hd = 1'b1; lat = W + 2; bsy = W + 1; eh = cur_hi; el = cur_lo;
    case (o)
      3'd1: begin
        p  = 64'(longint'($signed(a)) * longint'($signed(b)));
        eh = p[63:32]; el = p[31:0];
      end
      3'd2: begin
        p  = {32'b0, a} * {32'b0, b};
        eh = p[63:32]; el = p[31:0];
      end
      3'd3, 3'd4: begin
        if (b == '0) begin
          eh = a; el = '1; lat = 2; bsy = 1;
        end else if (o == 3'd3) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q  = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          ua = {32'b0, a}; ub = {32'b0, b};
          uq = ua / ub; ur = ua % ub;
          el = uq[31:0]; eh = ur[31:0];
        end
      end
      3'd5: begin eh = a; lat = 1; bsy = 0; end
      3'd6: begin el = a; lat = 1; bsy = 0; end
      default: hd = 1'b0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done hi=%h lo=%h with no outstanding request", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hi", {32'b0, hi}, {32'b0, mon_e.hi});
        chk("result_lo", {32'b0, lo}, {32'b0, mon_e.lo});
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, b,
                       input bit fl, input bit inject, input bit skip_neg);
    bit           hd;
    int           lat, bsy, cyc, bc;
    logic [W-1:0] eh, el;
    model(o, a, b, model_hi, model_lo, hd, lat, bsy, eh, el);
    if (!skip_neg) @(negedge clk);
    start = 1'b1; op_i = o; rs = a; rt = b; flush = fl;
    if (hd) begin
      exp_q.push_back('{hi: eh, lo: el});
      model_hi = eh; model_lo = el;
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    op_i = 3'($urandom); rs = $urandom; rt = $urandom;
    if (!hd) begin
      repeat (3) begin
        @(negedge clk);
        chk("nop_no_done", {63'b0, done}, 64'd0);
      end
      chk("nop_hi_hold", {32'b0, hi}, {32'b0, model_hi});
      chk("nop_lo_hold", {32'b0, lo}, {32'b0, model_lo});
      return;
    end
    cyc = 0; bc = 0;
    while (cyc <= 100) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
      if (done) break;
      if (inject && cyc == 5) begin
        start = 1'b1; op_i = 3'd1; rs = $urandom; rt = $urandom;
      end
      if (inject && cyc == 6) start = 1'b0;
    end
    chk("done_latency", 64'(cyc), 64'(lat));
    chk("busy_cycles", 64'(bc), 64'(bsy));
  endtask

  task automatic flush_op(input logic [2:0] o, input logic [W-1:0] a, b, input int at);
    @(negedge clk);
    start = 1'b1; op_i = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (at) @(negedge clk);
    chk("busy_before_flush", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_after_flush", {63'b0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi_hold", {32'b0, hi}, {32'b0, model_hi});
    chk("flush_lo_hold", {32'b0, lo}, {32'b0, model_lo});
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op_i = '0; rs = '0; rt = '0; flush = 1'b0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    rst = 1'b0;

    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("multu_hi", {32'b0, hi}, 64'h0000_0001);
    chk("multu_lo", {32'b0, lo}, 64'hFFFF_FFFE);
    do_op(3'd1, -32'sd3, 32'sd5, 1'b0, 1'b0, 1'b0);
    chk("mult_neg_lo", {32'b0, lo}, 64'hFFFF_FFF1);
    do_op(3'd3, -32'sd7, 32'sd2, 1'b0, 1'b0, 1'b0);
    chk("div_neg_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    chk("div_neg_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    do_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("div0_hi", {32'b0, hi}, 64'h1234_5678);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("div_ovf_lo", {32'b0, lo}, 64'h8000_0000);
    chk("div_ovf_hi", {32'b0, hi}, 64'd0);

    // Back-to-back MTHI / MTLO
    @(negedge clk);
    start = 1'b1; op_i = 3'd5; rs = 32'hAAAA_5555;
    exp_q.push_back('{hi: 32'hAAAA_5555, lo: model_lo});
    model_hi = 32'hAAAA_5555;
    @(negedge clk);
    chk("mthi_hi", {32'b0, hi}, 64'hAAAA_5555);
    chk("mthi_busy", {63'b0, busy}, 64'd0);
    op_i = 3'd6; rs = 32'h5555_AAAA;
    exp_q.push_back('{hi: model_hi, lo: 32'h5555_AAAA});
    model_lo = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", {32'b0, lo}, 64'h5555_AAAA);
    chk("mtlo_busy", {63'b0, busy}, 64'd0);

    do_op(3'd1, 32'h0001_2345, 32'hFFFF_0010, 1'b0, 1'b1, 1'b0);
    flush_op(3'd2, 32'hDEAD_BEEF, 32'h1234_5678, 10);
    flush_op(3'd1, 32'h7654_3210, 32'h0000_0300, W + 1);
    flush_op(3'd3, 32'h0000_1000, 32'h0000_0007, 5);
    do_op(3'd5, 32'hC0FF_EE00, 32'd0, 1'b1, 1'b0, 1'b0);
    do_op(3'd0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-DIV, then a new op in the first cycle after release
    @(negedge clk);
    start = 1'b1; op_i = 3'd3; rs = 32'h0BAD_F00D; rt = 32'h0000_0013;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_hi", {32'b0, hi}, 64'd0);
    chk("rst_mid_lo", {32'b0, lo}, 64'd0);
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_done", {63'b0, done}, 64'd0);
    model_hi = '0; model_lo = '0;
    rst = 1'b0;
    do_op(3'd2, 32'h0000_0010, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    chk("post_rst_lo", {32'b0, lo}, 64'h0000_1000);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
